udp_decoder: RTL and testbench
==============================

UDP_DECODER -- requirements
Module: UDP_decoder

Interface
REQ-001 SHALL have ports, one per line:
  clk  in  1  single clock; all state changes on rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  begin packet reception; sampled in IDLE or FIN
  pkg_av  in  1  pkg_data word valid this cycle
  pkg_data  in  32  UDP packet word, byte 0 in [31:24]
  src_ip  in  32  IPv4 source address for pseudo-header, stable from start to fin
  dest_ip  in  32  IPv4 destination address for pseudo-header, stable from start to fin
  src_port  out  16  captured source port
  dest_port  out  16  captured destination port
  len_out  out  16  payload length in bytes (UDP length - 8)
  data  out  32  payload word, unused trailing bytes zeroed
  data_wr  out  1  data valid strobe
  data_last  out  1  with data_wr, marks final payload word
  fin  out  1  packet complete; status outputs valid
  chksum_ok  out  1  checksum verified or absent (field = 0)
  len_err  out  1  UDP length field < 8

Function
REQ-002 SHALL implement states IDLE, RD_PORTS, RD_LEN, RD_DATA, FIN.
REQ-003 IDLE -> RD_PORTS when start=1; start in any other state except FIN ignored.
REQ-004 RD_PORTS: on pkg_av=1 latch src_port=[31:16], dest_port=[15:0]; -> RD_LEN; no advance while pkg_av=0.
REQ-005 RD_LEN: on pkg_av=1 latch udp_len=[31:16], chksum field=[15:0]; len_out=udp_len-8; bytes_left=udp_len-8.
REQ-006 RD_LEN exit: udp_len<8 -> FIN with len_err=1, len_out=0; udp_len=8 -> FIN; otherwise -> RD_DATA.
REQ-007 RD_DATA: each pkg_av=1 word consumes min(4, bytes_left) bytes; bytes_left saturates at 0; -> FIN on the word that brings bytes_left to 0.
REQ-008 data/data_wr SHALL be registered: asserted exactly one cycle after each accepted RD_DATA word; data_wr=0 in every other cycle.
REQ-009 Last word with 1-3 valid bytes: invalid low-order bytes zeroed in data and in checksum input; data_last=1 on that word only.
REQ-010 Checksum = 16-bit one's-complement sum (end-around carry) of src_ip halves, dest_ip halves, 0x0011, udp_len, both header words' halves, and all masked payload words' halves.
REQ-011 chksum_ok=1 if received checksum field = 0x0000 or final sum = 0xFFFF; else 0; len_err=1 forces chksum_ok=0.
REQ-012 fin, chksum_ok, len_err SHALL update in the cycle fin rises, simultaneously with the last data_wr when payload is present.
REQ-013 FIN holds all captured outputs and fin=1; start=1 in FIN -> RD_PORTS, clearing fin, chksum_ok, len_err, accumulator next cycle.
REQ-014 pkg_av in IDLE or FIN SHALL be ignored; words beyond udp_len are never consumed.

Reset
REQ-015 reset=1 at any clock edge, including mid-packet, SHALL force IDLE and zero all outputs, accumulator, and bytes_left; reset dominates start.
REQ-016 After reset release, the first start begins a clean packet with no residue from an aborted one.

Verification
REQ-017 Basic: src_ip=0xC0A80001, dest_ip=0xC0A80002, words 0x12340050, 0x000CCE60, 0xDEADBEEF -> src_port=0x1234, dest_port=0x0050, len_out=4, one data_wr with 0xDEADBEEF and data_last=1, fin=1, chksum_ok=1.
REQ-018 Same packet with checksum field 0xCE61 -> chksum_ok=0, fin=1; with field 0x0000 -> chksum_ok=1.
REQ-019 udp_len=0x000B, payload 0xAABBCCDD -> data=0xAABBCC00, data_last=1, len_out=3, checksum computed on masked word.
REQ-020 udp_len=0x0005 -> no data_wr, fin=1 after header, len_err=1, chksum_ok=0; udp_len=0x0008 -> fin, no data_wr, len_out=0.
REQ-021 pkg_av toggled 1/0 every cycle over a 5-word payload -> exactly 5 data_wr pulses, each 1 cycle after its input word, identical result to gap-free stream.
REQ-022 reset during RD_DATA then a fresh packet -> all outputs 0 during reset; second packet's results independent of the first.

Source files
------------

// File: rtl/udp_decoder.sv
// -----------------------------------------------------------------------------
// udp_decoder
//
// Purpose:
//   Receives a UDP datagram one 32-bit word at a time. It captures the header
//   fields, streams the payload out with unused trailing bytes zeroed, and
//   verifies the UDP checksum. The checksum covers the IPv4 pseudo-header
//   (src_ip, dest_ip, protocol 17, UDP length), the UDP header and the payload.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   begin packet reception (honoured in IDLE or FIN)
//   pkg_av     in   1   pkg_data valid this cycle
//   pkg_data   in  32   packet word, byte 0 in [31:24]
//   src_ip     in  32   pseudo-header source address, stable start..fin
//   dest_ip    in  32   pseudo-header destination address, stable start..fin
//   src_port   out 16   captured source port
//   dest_port  out 16   captured destination port
//   len_out    out 16   payload length in bytes (UDP length - 8)
//   data       out 32   payload word, unused trailing bytes zeroed
//   data_wr    out  1   payload word strobe (one cycle after accepted word)
//   data_last  out  1   with data_wr, marks the final payload word
//   fin        out  1   packet complete, status outputs valid
//   chksum_ok  out  1   checksum verified, or checksum field was zero
//   len_err    out  1   UDP length field below 8
// -----------------------------------------------------------------------------
module udp_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pkg_av,
    input  logic [31:0] pkg_data,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    output logic [15:0] src_port,
    output logic [15:0] dest_port,
    output logic [15:0] len_out,
    output logic [31:0] data,
    output logic        data_wr,
    output logic        data_last,
    output logic        fin,
    output logic        chksum_ok,
    output logic        len_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_PORTS = 3'd1,
        ST_RD_LEN   = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_FIN      = 3'd4
    } state_t;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam logic [15:0] IP_PROTO_UDP  = 16'h0011;
    localparam logic [15:0] SUM_ALL_ONES  = 16'hFFFF;

    // 16-bit one's-complement addition with end-around carry. A single fold
    // is sufficient: the folded value can never carry out again.
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

    // Keeps only the bytes still owed by the packet. Byte 0 sits in [31:24],
    // so a short final word keeps its high-order bytes.
    function automatic logic [31:0] tail_mask(input logic [15:0] bytes_left);
        logic [31:0] mask;
        if (bytes_left >= 16'd4) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            case (bytes_left[1:0])
                2'd3:    mask = 32'hFFFF_FF00;
                2'd2:    mask = 32'hFFFF_0000;
                2'd1:    mask = 32'hFF00_0000;
                default: mask = 32'h0000_0000;
            endcase
        end
        return mask;
    endfunction

    state_t      state_q,      state_d;
    logic [15:0] src_port_q,   src_port_d;
    logic [15:0] dest_port_q,  dest_port_d;
    logic [15:0] len_out_q,    len_out_d;
    logic [15:0] chk_field_q,  chk_field_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [15:0] acc_q,        acc_d;
    logic [31:0] data_q,       data_d;
    logic        data_wr_q,    data_wr_d;
    logic        data_last_q,  data_last_d;
    logic        fin_q,        fin_d;
    logic        chksum_ok_q,  chksum_ok_d;
    logic        len_err_q,    len_err_d;

    logic [15:0] pseudo_sum_s;
    logic [15:0] hdr_sum_s;
    logic [15:0] len_sum_s;
    logic [15:0] udp_len_s;
    logic [31:0] masked_s;
    logic [15:0] data_sum_s;

    // Next-state and next-output computation for the whole decoder.
    always_comb begin
        state_d      = state_q;
        src_port_d   = src_port_q;
        dest_port_d  = dest_port_q;
        len_out_d    = len_out_q;
        chk_field_d  = chk_field_q;
        bytes_left_d = bytes_left_q;
        acc_d        = acc_q;
        data_d       = data_q;
        data_wr_d    = 1'b0;
        data_last_d  = 1'b0;
        fin_d        = fin_q;
        chksum_ok_d  = chksum_ok_q;
        len_err_d    = len_err_q;

        // Address and protocol part of the pseudo-header; the length part is
        // added when the UDP length field arrives.
        pseudo_sum_s = oc_add(oc_add(oc_add(src_ip[31:16], src_ip[15:0]),
                                     oc_add(dest_ip[31:16], dest_ip[15:0])),
                              IP_PROTO_UDP);
        hdr_sum_s    = oc_add(acc_q, oc_add(pkg_data[31:16], pkg_data[15:0]));
        udp_len_s    = pkg_data[31:16];
        // The UDP length is counted twice: once in the header word, once in
        // the pseudo-header.
        len_sum_s    = oc_add(hdr_sum_s, udp_len_s);
        masked_s     = pkg_data & tail_mask(bytes_left_q);
        data_sum_s   = oc_add(acc_q, oc_add(masked_s[31:16], masked_s[15:0]));

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    // New packet: the accumulator restarts from the pseudo-
                    // header addresses, dropping anything from before.
                    state_d      = ST_RD_PORTS;
                    acc_d        = pseudo_sum_s;
                    bytes_left_d = 16'd0;
                    fin_d        = 1'b0;
                    chksum_ok_d  = 1'b0;
                    len_err_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_RD_PORTS: begin
                if (pkg_av) begin
                    src_port_d  = pkg_data[31:16];
                    dest_port_d = pkg_data[15:0];
                    acc_d       = hdr_sum_s;
                    state_d     = ST_RD_LEN;
                end else begin
                    state_d = ST_RD_PORTS;
                end
            end

            ST_RD_LEN: begin
                if (pkg_av) begin
                    chk_field_d = pkg_data[15:0];
                    acc_d       = len_sum_s;
                    if (udp_len_s < UDP_HDR_BYTES) begin
                        len_out_d    = 16'd0;
                        bytes_left_d = 16'd0;
                        len_err_d    = 1'b1;
                        chksum_ok_d  = 1'b0;
                        fin_d        = 1'b1;
                        state_d      = ST_FIN;
                    end else if (udp_len_s == UDP_HDR_BYTES) begin
                        len_out_d    = 16'd0;
                        bytes_left_d = 16'd0;
                        chksum_ok_d  = (pkg_data[15:0] == 16'h0000) ||
                                       (len_sum_s == SUM_ALL_ONES);
                        fin_d        = 1'b1;
                        state_d      = ST_FIN;
                    end else begin
                        len_out_d    = udp_len_s - UDP_HDR_BYTES;
                        bytes_left_d = udp_len_s - UDP_HDR_BYTES;
                        state_d      = ST_RD_DATA;
                    end
                end else begin
                    state_d = ST_RD_LEN;
                end
            end

            ST_RD_DATA: begin
                if (pkg_av) begin
                    data_d    = masked_s;
                    data_wr_d = 1'b1;
                    acc_d     = data_sum_s;
                    if (bytes_left_q <= 16'd4) begin
                        // Final word: status rises together with this strobe.
                        bytes_left_d = 16'd0;
                        data_last_d  = 1'b1;
                        chksum_ok_d  = (chk_field_q == 16'h0000) ||
                                       (data_sum_s == SUM_ALL_ONES);
                        fin_d        = 1'b1;
                        state_d      = ST_FIN;
                    end else begin
                        bytes_left_d = bytes_left_q - 16'd4;
                        state_d      = ST_RD_DATA;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to zero / IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            src_port_q   <= 16'd0;
            dest_port_q  <= 16'd0;
            len_out_q    <= 16'd0;
            chk_field_q  <= 16'd0;
            bytes_left_q <= 16'd0;
            acc_q        <= 16'd0;
            data_q       <= 32'd0;
            data_wr_q    <= 1'b0;
            data_last_q  <= 1'b0;
            fin_q        <= 1'b0;
            chksum_ok_q  <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_port_q   <= src_port_d;
            dest_port_q  <= dest_port_d;
            len_out_q    <= len_out_d;
            chk_field_q  <= chk_field_d;
            bytes_left_q <= bytes_left_d;
            acc_q        <= acc_d;
            data_q       <= data_d;
            data_wr_q    <= data_wr_d;
            data_last_q  <= data_last_d;
            fin_q        <= fin_d;
            chksum_ok_q  <= chksum_ok_d;
            len_err_q    <= len_err_d;
        end
    end

    assign src_port  = src_port_q;
    assign dest_port = dest_port_q;
    assign len_out   = len_out_q;
    assign data      = data_q;
    assign data_wr   = data_wr_q;
    assign data_last = data_last_q;
    assign fin       = fin_q;
    assign chksum_ok = chksum_ok_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_udp_decoder.sv
// -----------------------------------------------------------------------------
// tb_udp_decoder
//
// Directed testbench for udp_decoder. Inputs change just after a falling edge
// and outputs are sampled on the falling edge, half a cycle after the rising
// edge that updated them. Expected checksum fields were computed by hand for
// src_ip=C0A80001, dest_ip=C0A80002, ports 1234/0050:
//   len 0x000C, payload DEADBEEF          -> valid field CE60
//   len 0x000B, payload AABBCC(DD masked) -> valid field F543
//   len 0x001C, payload 00010002..0009000A -> valid field 6BA7
// -----------------------------------------------------------------------------
module tb_udp_decoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic        pkg_av;
    logic [31:0] pkg_data;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [15:0] len_out;
    logic [31:0] data;
    logic        data_wr;
    logic        data_last;
    logic        fin;
    logic        chksum_ok;
    logic        len_err;

    int n_tests = 0;
    int n_fail  = 0;

    udp_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pkg_av    (pkg_av),
        .pkg_data  (pkg_data),
        .src_ip    (src_ip),
        .dest_ip   (dest_ip),
        .src_port  (src_port),
        .dest_port (dest_port),
        .len_out   (len_out),
        .data      (data),
        .data_wr   (data_wr),
        .data_last (data_last),
        .fin       (fin),
        .chksum_ok (chksum_ok),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_src_port"},  {16'd0, src_port},  32'd0);
        check_val({tag, "_dest_port"}, {16'd0, dest_port}, 32'd0);
        check_val({tag, "_len_out"},   {16'd0, len_out},   32'd0);
        check_val({tag, "_data"},      data,               32'd0);
        check_val({tag, "_flags"},
                  {27'd0, data_wr, data_last, fin, chksum_ok, len_err}, 32'd0);
    endtask

    task automatic check_status(input string tag, input logic e_fin,
                                input logic e_ok, input logic e_lerr);
        check_val({tag, "_fin"},       {31'd0, fin},       {31'd0, e_fin});
        check_val({tag, "_chksum_ok"}, {31'd0, chksum_ok}, {31'd0, e_ok});
        check_val({tag, "_len_err"},   {31'd0, len_err},   {31'd0, e_lerr});
    endtask

    task automatic check_hdr(input string tag, input logic [15:0] e_src,
                             input logic [15:0] e_dst, input logic [15:0] e_len);
        check_val({tag, "_src_port"},  {16'd0, src_port},  {16'd0, e_src});
        check_val({tag, "_dest_port"}, {16'd0, dest_port}, {16'd0, e_dst});
        check_val({tag, "_len_out"},   {16'd0, len_out},   {16'd0, e_len});
    endtask

    // Pulse start for one cycle; status must be cleared afterwards.
    task automatic start_pkt(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_status({tag, "_start"}, 1'b0, 1'b0, 1'b0);
    endtask

    // Present one word for one cycle, then check the strobe that follows.
    // With gap set, an idle cycle (garbage data, pkg_av=0) follows.
    task automatic send_word(input string tag, input logic [31:0] w,
                             input logic e_wr, input logic [31:0] e_data,
                             input logic e_last, input logic gap);
        pkg_data = w;
        pkg_av   = 1'b1;
        @(negedge clk);
        pkg_av   = 1'b0;
        pkg_data = 32'hFFFF_FFFF;
        check_val({tag, "_data_wr"}, {31'd0, data_wr}, {31'd0, e_wr});
        if (e_wr) begin
            check_val({tag, "_data"},      data,                e_data);
            check_val({tag, "_data_last"}, {31'd0, data_last},  {31'd0, e_last});
        end
        if (gap) begin
            @(negedge clk);
            check_val({tag, "_gap_wr"}, {31'd0, data_wr}, 32'd0);
        end
    endtask

    // Basic one-word packet with a chosen checksum field.
    task automatic basic_pkt(input string tag, input logic [15:0] field, input logic e_ok);
        start_pkt(tag);
        send_word({tag, "_w0"}, 32'h1234_0050, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val({tag, "_hdr_fin"}, {31'd0, fin}, 32'd0);
        send_word({tag, "_w1"}, {16'h000C, field}, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val({tag, "_pre_fin"}, {31'd0, fin}, 32'd0);
        send_word({tag, "_w2"}, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check_status(tag, 1'b1, e_ok, 1'b0);
        check_hdr(tag, 16'h1234, 16'h0050, 16'd4);
    endtask

    // Five-word payload, optionally with a gap after every word.
    task automatic five_word_pkt(input string tag, input logic gap);
        logic [31:0] w;
        start_pkt(tag);
        send_word({tag, "_h0"}, 32'h1234_0050, 1'b0, 32'd0, 1'b0, gap);
        send_word({tag, "_h1"}, 32'h001C_6BA7, 1'b0, 32'd0, 1'b0, gap);
        for (int i = 0; i < 5; i++) begin
            w = {16'(2 * i + 1), 16'(2 * i + 2)};
            send_word($sformatf("%s_p%0d", tag, i), w, 1'b1, w, (i == 4), gap);
            if (i < 4) begin
                check_val($sformatf("%s_p%0d_fin", tag, i), {31'd0, fin}, 32'd0);
            end
        end
        check_status(tag, 1'b1, 1'b1, 1'b0);
        check_hdr(tag, 16'h1234, 16'h0050, 16'd20);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        pkg_av   = 1'b0;
        pkg_data = 32'd0;
        src_ip   = 32'hC0A8_0001;
        dest_ip  = 32'hC0A8_0002;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // pkg_av while idle must be ignored
        send_word("idle_av", 32'h1111_2222, 1'b0, 32'd0, 1'b0, 1'b0);
        check_zero("idle");

        basic_pkt("basic", 16'hCE60, 1'b1);
        @(negedge clk);
        check_status("hold", 1'b1, 1'b1, 1'b0);
        check_val("hold_data_wr", {31'd0, data_wr}, 32'd0);
        check_val("hold_data", data, 32'hDEAD_BEEF);

        basic_pkt("badsum", 16'hCE61, 1'b0);
        basic_pkt("nosum",  16'h0000, 1'b1);

        // 3-byte payload: masked data and checksum over the masked word
        start_pkt("short");
        send_word("short_h0", 32'h1234_0050, 1'b0, 32'd0, 1'b0, 1'b0);
        send_word("short_h1", 32'h000B_F543, 1'b0, 32'd0, 1'b0, 1'b0);
        send_word("short_p0", 32'hAABB_CCDD, 1'b1, 32'hAABB_CC00, 1'b1, 1'b0);
        check_status("short", 1'b1, 1'b1, 1'b0);
        check_hdr("short", 16'h1234, 16'h0050, 16'd3);
        // extra word beyond udp_len is not consumed
        send_word("extra", 32'h1111_1111, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("extra_data", data, 32'hAABB_CC00);
        check_status("extra", 1'b1, 1'b1, 1'b0);

        // length field below 8
        start_pkt("lerr");
        send_word("lerr_h0", 32'h1234_0050, 1'b0, 32'd0, 1'b0, 1'b0);
        send_word("lerr_h1", 32'h0005_0000, 1'b0, 32'd0, 1'b0, 1'b0);
        check_status("lerr", 1'b1, 1'b0, 1'b1);
        check_hdr("lerr", 16'h1234, 16'h0050, 16'd0);

        // header-only packet
        start_pkt("hdronly");
        send_word("hdronly_h0", 32'hABCD_0102, 1'b0, 32'd0, 1'b0, 1'b0);
        send_word("hdronly_h1", 32'h0008_0000, 1'b0, 32'd0, 1'b0, 1'b0);
        check_status("hdronly", 1'b1, 1'b1, 1'b0);
        check_hdr("hdronly", 16'hABCD, 16'h0102, 16'd0);

        five_word_pkt("stream", 1'b0);
        five_word_pkt("gapped", 1'b1);

        // reset mid-payload, then a clean packet
        start_pkt("abort");
        send_word("abort_h0", 32'h5555_6666, 1'b0, 32'd0, 1'b0, 1'b0);
        send_word("abort_h1", 32'h001C_0001, 1'b0, 32'd0, 1'b0, 1'b0);
        send_word("abort_p0", 32'h0102_0304, 1'b1, 32'h0102_0304, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_zero("abort_rst");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_zero("rst_dom");
        reset = 1'b0;
        @(negedge clk);
        basic_pkt("after", 16'hCE60, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
